// File: rtl/maxnet_controller.sv
// Sequencing FSM for the 4-neuron MaxNet datapath: load, then compute/update until one neuron wins.
// Optional iteration cap enabled by defining MAXNET_ITER_LIMIT_EN.
module maxnet_controller #(
  parameter int unsigned ITER_W      = 4,
  parameter int unsigned CALC_CYCLES = 1,
  parameter int unsigned MAX_ITER    = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        active,
  output logic              sel_mem,
  output logic              ld_reg,
  output logic              busy,
  output logic              done,
  output logic              none,
  output logic              error,
  output logic [1:0]        winner,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned CntW = 4;

  if (CALC_CYCLES < 1 || CALC_CYCLES > 15) begin : g_bad_calc_cycles
    $error("CALC_CYCLES must be in 1..15");
  end
  if (MAX_ITER >= (1 << ITER_W)) begin : g_bad_max_iter
    $error("MAX_ITER must fit in ITER_W bits");
  end

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCheck,
    StCalc,
    StUpdate,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [1:0]        winner_q, winner_d;
  logic              none_q, none_d;
  logic              error_q, error_d;
  logic              sel_mem_q, sel_mem_d;
  logic              ld_reg_q, ld_reg_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              at_most_one;
  logic [1:0]        low_idx;
  logic              cap_hit;

  // Clearing the lowest set bit leaves zero iff popcount <= 1.
  assign at_most_one = ((active & (active - 4'd1)) == 4'd0);

  always_comb begin
    low_idx = 2'd0;
    if (active[0])      low_idx = 2'd0;
    else if (active[1]) low_idx = 2'd1;
    else if (active[2]) low_idx = 2'd2;
    else if (active[3]) low_idx = 2'd3;
  end

`ifdef MAXNET_ITER_LIMIT_EN
  assign cap_hit = (iter_q == ITER_W'(MAX_ITER));
`else
  assign cap_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    iter_d   = iter_q;
    winner_d = winner_q;
    none_d   = none_q;
    error_d  = error_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          // Results clear on the edge that enters LOAD so done drops with them.
          state_d  = StLoad;
          iter_d   = '0;
          winner_d = 2'd0;
          none_d   = 1'b0;
          error_d  = 1'b0;
        end
      end
      StLoad: begin
        state_d = StCheck;
      end
      StCheck: begin
        if (at_most_one) begin
          state_d  = StDone;
          winner_d = low_idx;
          none_d   = (active == 4'd0);
        end else if (cap_hit) begin
          state_d  = StDone;
          error_d  = 1'b1;
        end else begin
          state_d  = StCalc;
          cnt_d    = CntW'(CALC_CYCLES - 1);
        end
      end
      StCalc: begin
        if (cnt_q == '0) begin
          state_d = StUpdate;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StUpdate: begin
        state_d = StCheck;
        if (iter_q != '1) begin
          iter_d = iter_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Control outputs are registered from the next state so they line up with state_q.
  always_comb begin
    sel_mem_d = (state_d == StLoad);
    ld_reg_d  = (state_d == StLoad) || (state_d == StUpdate);
    busy_d    = (state_d != StIdle) && (state_d != StDone);
    done_d    = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      iter_q    <= '0;
      winner_q  <= 2'd0;
      none_q    <= 1'b0;
      error_q   <= 1'b0;
      sel_mem_q <= 1'b0;
      ld_reg_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      iter_q    <= iter_d;
      winner_q  <= winner_d;
      none_q    <= none_d;
      error_q   <= error_d;
      sel_mem_q <= sel_mem_d;
      ld_reg_q  <= ld_reg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sel_mem    = sel_mem_q;
  assign ld_reg     = ld_reg_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign none       = none_q;
  assign winner     = winner_q;
  assign iter_count = iter_q;

`ifdef MAXNET_ITER_LIMIT_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: unit 0 uses CALC_CYCLES=1, unit 1 uses CALC_CYCLES=4.
module tb_maxnet_controller;

  logic       clk;
  logic       rst;
  logic [1:0] start_s;
  logic [3:0] active_w [2];
  logic [1:0] sel_w, ld_w, busy_w, done_w, none_w, err_w;
  logic [1:0] win_w [2];
  logic [3:0] iter_w [2];

  logic [3:0] seq [16];
  int         upd [2];
  int         chk_cnt;
  int         pass_cnt;

  maxnet_controller #(.ITER_W(4), .CALC_CYCLES(1), .MAX_ITER(3)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_s[0]), .active(active_w[0]),
    .sel_mem(sel_w[0]), .ld_reg(ld_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .none(none_w[0]), .error(err_w[0]), .winner(win_w[0]), .iter_count(iter_w[0])
  );

  maxnet_controller #(.ITER_W(4), .CALC_CYCLES(4), .MAX_ITER(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_s[1]), .active(active_w[1]),
    .sel_mem(sel_w[1]), .ld_reg(ld_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .none(none_w[1]), .error(err_w[1]), .winner(win_w[1]), .iter_count(iter_w[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Neuron register model: count of updates since load selects the active pattern.
  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (rst) upd[u] <= 0;
      else if (ld_w[u]) upd[u] <= sel_w[u] ? 0 : upd[u] + 1;
    end
  end

  always_comb begin
    active_w[0] = seq[(upd[0] > 15) ? 15 : upd[0]];
    active_w[1] = seq[(upd[1] > 15) ? 15 : upd[1]];
  end

  task automatic set_seq(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    for (int i = 0; i < 16; i++) seq[i] = a2;
    seq[0] = a0;
    seq[1] = a1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk_cnt++;
      if ({sel_w[u], ld_w[u], busy_w[u], done_w[u], none_w[u], err_w[u]} !== 6'b0) begin
        $display("FAIL reset_ctrl u%0d: got %b expected 000000", u,
                 {sel_w[u], ld_w[u], busy_w[u], done_w[u], none_w[u], err_w[u]});
      end else pass_cnt++;
      chk_cnt++;
      if ({win_w[u], iter_w[u]} !== 6'b0) begin
        $display("FAIL reset_data u%0d: winner=%0d iter=%0d expected 0/0", u, win_w[u], iter_w[u]);
      end else pass_cnt++;
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one start-to-done transaction and checks latency, pulses and results.
  task automatic do_run(input int u, input int n, input logic [1:0] w, input logic nn,
                        input string nm);
    int cc;
    int cyc;
    int lds;
    int sels;
    int exp_lat;
    cc = (u == 0) ? 1 : 4;
    cyc = 0;
    lds = 0;
    sels = 0;
    exp_lat = 3 + n * (cc + 2);
    @(negedge clk);
    start_s[u] = 1'b1;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      // A start pulse during CHECK must be ignored.
      start_s[u] = (cyc == 2);
      if (ld_w[u]) lds++;
      if (sel_w[u]) sels++;
      if (cyc == 1) begin
        chk_cnt++;
        if (done_w[u] !== 1'b0 || iter_w[u] !== 4'd0) begin
          $display("FAIL %s load_clear: done=%b iter=%0d expected 0/0", nm, done_w[u], iter_w[u]);
        end else pass_cnt++;
      end
    end while (!done_w[u] && cyc < 300);
    start_s[u] = 1'b0;
    chk_cnt++;
    if (cyc !== exp_lat) $display("FAIL %s latency: got %0d expected %0d", nm, cyc, exp_lat);
    else pass_cnt++;
    chk_cnt++;
    if (lds !== 1 + n) $display("FAIL %s ld_reg_pulses: got %0d expected %0d", nm, lds, 1 + n);
    else pass_cnt++;
    chk_cnt++;
    if (sels !== 1) $display("FAIL %s sel_mem_cycles: got %0d expected 1", nm, sels);
    else pass_cnt++;
    chk_cnt++;
    if (iter_w[u] !== 4'(n)) $display("FAIL %s iter_count: got %0d expected %0d", nm, iter_w[u], n);
    else pass_cnt++;
    chk_cnt++;
    if (win_w[u] !== w || none_w[u] !== nn || err_w[u] !== 1'b0 || busy_w[u] !== 1'b0) begin
      $display("FAIL %s result: winner=%0d none=%b error=%b busy=%b expected %0d/%b/0/0",
               nm, win_w[u], none_w[u], err_w[u], busy_w[u], w, nn);
    end else pass_cnt++;
  endtask

  task automatic test_resolved();
    set_seq(4'b0100, 4'b0100, 4'b0100);
    do_run(0, 0, 2'd2, 1'b0, "resolved");
  endtask

  task automatic test_two_iter();
    set_seq(4'b1111, 4'b0011, 4'b0001);
    do_run(0, 2, 2'd0, 1'b0, "two_iter");
    set_seq(4'b1111, 4'b1010, 4'b1000);
    do_run(0, 2, 2'd3, 1'b0, "winner3");
  endtask

  task automatic test_suppressed();
    set_seq(4'b1111, 4'b0000, 4'b0000);
    do_run(0, 1, 2'd0, 1'b1, "suppressed");
  endtask

  task automatic test_back_to_back();
    set_seq(4'b0110, 4'b0010, 4'b0010);
    do_run(0, 1, 2'd1, 1'b0, "restart");
  endtask

  task automatic test_cap();
    int cyc;
    cyc = 0;
    set_seq(4'b1100, 4'b1100, 4'b1100);
    @(negedge clk);
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
`ifdef MAXNET_ITER_LIMIT_EN
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!done_w[0] && cyc < 300);
    chk_cnt++;
    if (cyc !== 11) $display("FAIL cap_latency: got %0d expected 11", cyc);
    else pass_cnt++;
    chk_cnt++;
    if (err_w[0] !== 1'b1 || iter_w[0] !== 4'd3 || win_w[0] !== 2'd0 || none_w[0] !== 1'b0) begin
      $display("FAIL cap_result: error=%b iter=%0d winner=%0d none=%b expected 1/3/0/0",
               err_w[0], iter_w[0], win_w[0], none_w[0]);
    end else pass_cnt++;
`else
    repeat (200) @(posedge clk);
    #1;
    chk_cnt++;
    if (done_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
      $display("FAIL nocap_running: done=%b busy=%b expected 0/1", done_w[0], busy_w[0]);
    end else pass_cnt++;
    chk_cnt++;
    if (iter_w[0] !== 4'd15) $display("FAIL nocap_saturate: got %0d expected 15", iter_w[0]);
    else pass_cnt++;
    chk_cnt++;
    if (err_w[0] !== 1'b0) $display("FAIL nocap_error: got %b expected 0", err_w[0]);
    else pass_cnt++;
`endif
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    int lds;
    int bsy;
    cyc = 0;
    lds = 0;
    bsy = 0;
    set_seq(4'b1111, 4'b1111, 4'b1111);
    @(negedge clk);
    start_s[1] = 1'b1;
    @(negedge clk);
    start_s[1] = 1'b0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!(ld_w[1] && !sel_w[1]) && cyc < 100);
    chk_cnt++;
    if (cyc >= 100) $display("FAIL midrun_update_seen: got timeout expected UPDATE");
    else pass_cnt++;
    // UPDATE -> CHECK -> CALC
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({sel_w[1], ld_w[1], busy_w[1], done_w[1], none_w[1], err_w[1], win_w[1], iter_w[1]}
        !== 12'b0) begin
      $display("FAIL midrun_reset_outputs: got %b expected all 0",
               {sel_w[1], ld_w[1], busy_w[1], done_w[1], none_w[1], err_w[1], win_w[1], iter_w[1]});
    end else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (ld_w[0] || ld_w[1]) lds++;
      if (busy_w[0] || busy_w[1]) bsy++;
    end
    chk_cnt++;
    if (lds !== 0 || bsy !== 0) begin
      $display("FAIL midrun_quiet: ld_cycles=%0d busy_cycles=%0d expected 0/0", lds, bsy);
    end else pass_cnt++;
    set_seq(4'b1111, 4'b0011, 4'b0001);
    do_run(1, 2, 2'd0, 1'b0, "after_reset_cc4");
  endtask

  task automatic test_calc4();
    set_seq(4'b1111, 4'b0000, 4'b0000);
    do_run(1, 1, 2'd0, 1'b1, "cc4_suppressed");
    set_seq(4'b1000, 4'b1000, 4'b1000);
    do_run(1, 0, 2'd3, 1'b0, "cc4_restart");
  endtask

  initial begin
    chk_cnt = 0;
    pass_cnt = 0;
    start_s = 2'b00;
    rst = 1'b1;
    set_seq(4'b0000, 4'b0000, 4'b0000);
    test_reset();
    test_resolved();
    test_two_iter();
    test_suppressed();
    test_back_to_back();
    test_cap();
    test_reset_mid_run();
    test_calc4();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
